// File: rtl/xorshift_cmd_ctrl_if.sv
// Host command channel of the xorshift command sequencer: byte commands in, read bytes out.
interface xorshift_cmd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rd_data, rd_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/xorshift_cmd_ctrl.sv
// Command sequencer for the xorshift32 core: seed assembly/commit, burst stepping, state readback.
// Optional step counter readback is enabled by defining XSCTRL_STEP_COUNT_EN.
module xorshift_cmd_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  xorshift_cmd_ctrl_if.slave  cmd,
  output logic                core_load,
  output logic [31:0]         core_seed,
  output logic                core_step,
  input  logic [31:0]         core_state,
  output logic                busy,
  output logic                err
);

  localparam int unsigned SEED_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 3;
  localparam int unsigned REM_W  = 9;

  localparam logic [1:0] OP_SEED   = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_READ = 2'd3
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [SEED_W-1:0]   seed_sr;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [REM_W-1:0]    rem;

  logic                ready_q;
  logic                load_q;
  logic                rv_q;
  logic                busy_q;
  logic                err_q;
  logic [BYTE_W-1:0]   rd_q;

  logic                ready_d;
  logic                load_d;
  logic                rv_d;
  logic                busy_d;
  logic                err_d;
  logic [BYTE_W-1:0]   rd_d;

  logic                acc;
  logic                seed_ok;
  logic [BYTE_W-1:0]   rd_sel;

  // ready_q is held low through reset so nothing is accepted until one clean edge after release
  assign cmd.cmd_ready = ready_q & ena;
  assign acc           = cmd.cmd_valid & cmd.cmd_ready;
  assign seed_ok       = (byte_cnt == BCNT_W'(4)) && (seed_sr != '0);

  assign core_load    = load_q & ena;
  assign core_step    = (state == ST_RUN) & ena;
  assign core_seed    = seed_sr;
  assign cmd.rd_valid = rv_q & ena;
  assign cmd.rd_data  = rd_q;
  assign busy         = busy_q;
  assign err          = err_q;

`ifdef XSCTRL_STEP_COUNT_EN
  logic [CNT_W-1:0] step_cnt;
  logic [15:0]      cnt_ext;

  assign cnt_ext = 16'(step_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (ena) begin
      if (acc && (cmd.cmd_op == OP_COMMIT) && seed_ok) begin
        step_cnt <= '0;
      end else if (state == ST_RUN) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end
    end
  end
`endif

  // Read byte selection, sampled at the accept edge
  always_comb begin
    rd_sel = core_state[7:0];
    case (cmd.cmd_data[1:0])
      2'd1:    rd_sel = core_state[15:8];
      2'd2:    rd_sel = core_state[23:16];
      2'd3:    rd_sel = core_state[31:24];
      default: rd_sel = core_state[7:0];
    endcase
`ifdef XSCTRL_STEP_COUNT_EN
    if (cmd.cmd_data[2]) begin
      rd_sel = cmd.cmd_data[0] ? cnt_ext[15:8] : cnt_ext[7:0];
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          case (cmd.cmd_op)
            OP_COMMIT: state_d = ST_LOAD;
            OP_STEP:   state_d = ST_RUN;
            OP_READ:   state_d = ST_READ;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_RUN:  if (rem == REM_W'(1)) state_d = ST_IDLE;
      ST_READ: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    load_d  = 1'b0;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    err_d   = err_q;
    if (acc) begin
      case (cmd.cmd_op)
        OP_COMMIT: begin
          load_d = seed_ok;
          if (!seed_ok) err_d = 1'b1;
        end
        OP_READ: begin
          rv_d = 1'b1;
          rd_d = rd_sel;
          if (cmd.cmd_data[7]) err_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output registers and datapath; everything freezes while ena is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      load_q   <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
      seed_sr  <= '0;
      byte_cnt <= '0;
      rem      <= '0;
    end else if (ena) begin
      ready_q <= ready_d;
      load_q  <= load_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      if (acc && (cmd.cmd_op == OP_SEED)) begin
        seed_sr <= {seed_sr[SEED_W-BYTE_W-1:0], cmd.cmd_data};
        if (byte_cnt != BCNT_W'(4)) byte_cnt <= byte_cnt + BCNT_W'(1);
      end
      if (acc && (cmd.cmd_op == OP_COMMIT)) begin
        byte_cnt <= '0;
      end
      // A zero step operand means a full 256-step burst
      if (acc && (cmd.cmd_op == OP_STEP)) begin
        rem <= (cmd.cmd_data == '0) ? REM_W'(256) : REM_W'(cmd.cmd_data);
      end else if (state == ST_RUN) begin
        rem <= rem - REM_W'(1);
      end
    end
  end

endmodule
